dma_rx_burst: RTL

- Parametrised successor of the fixed 3-byte serial-RX DMA engine.
- Moves a frame of NUM_BYTES bytes from the serial RX FIFO into RAM at BASE_ADDR+0 … BASE_ADDR+NUM_BYTES-1, then pulses Dma_End.
- Reports the transferred byte count and handles short frames.
- Sits between the serial RX FIFO, the shared RAM bus and the CPU bus arbiter (Bus_req/Bus_grant).

---
 rtl/global_pkg.sv | 15 +
 rtl/dma_rx_timeout_cnt.sv | 36 +++
 rtl/dma_rx_burst.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/global_pkg.sv
// Shared system constants and the RX DMA state encoding.
package global_pkg;

  localparam int unsigned DMA_RX_BUFFER_BASE = 32'h20;

  typedef enum logic [2:0] {
    StIdle,
    StBusReq,
    StRead,
    StWrite,
    StWait,
    StDone
  } dma_rx_state_t;

endpackage

// File: rtl/dma_rx_timeout_cnt.sv
// Idle-wait counter for the RX DMA: counts enabled cycles, flags when the limit is reached.
module dma_rx_timeout_cnt
  import global_pkg::*;
#(
  parameter int unsigned CntW = 4
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [CntW-1:0] limit_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == limit_i);

endmodule

// File: rtl/dma_rx_burst.sv
// Burst RX DMA: moves a NUM_BYTES frame from the serial RX FIFO into RAM at BASE_ADDR.
// Optional idle-wait timeout on short frames is built with `define DMA_RX_TIMEOUT_EN.
module dma_rx_burst
  import global_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_BYTES   = 3,
  parameter int unsigned BASE_ADDR   = DMA_RX_BUFFER_BASE,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Ena,
  output logic                           Dma_End,
  output logic                           Dma_Timeout,
  output logic [$clog2(NUM_BYTES+1)-1:0] Byte_Count,
  output logic [ADDR_W-1:0]              Address,
  output logic [DATA_W-1:0]              Databus,
  input  logic [DATA_W-1:0]              RX_Data,
  input  logic                           RX_Full,
  input  logic                           RX_Empty,
  output logic                           Data_Read,
  output logic                           Cs,
  output logic                           Wena,
  output logic                           Bus_req,
  input  logic                           Bus_grant
);

  localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned CntW = $clog2(NUM_BYTES + 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  dma_rx_state_t   state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            active;
  logic            unused_rx_full;

  assign unused_rx_full = RX_Full;
  // Outputs are also silenced in a reset cycle so nothing reaches RAM or the FIFO.
  assign active = Ena && Rst_n;

`ifdef DMA_RX_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic tmo_q, tmo_d;
  logic wait_clear, wait_en, wait_expired;

  assign wait_en    = active && (state_q == StWait) && RX_Empty;
  assign wait_clear = active && ((state_q != StWait) || !RX_Empty || wait_expired);

  dma_rx_timeout_cnt #(
    .CntW(TmoW)
  ) u_timeout_cnt (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .clear_i  (wait_clear),
    .enable_i (wait_en),
    .limit_i  (TmoW'(TIMEOUT_CYC - 1)),
    .expired_o(wait_expired)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      tmo_q <= 1'b0;
    end else if (Ena) begin
      tmo_q <= tmo_d;
    end
  end
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
`ifdef DMA_RX_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    Dma_End     = 1'b0;
    Dma_Timeout = 1'b0;
    Byte_Count  = '0;
    Address     = '0;
    Databus     = '0;
    Data_Read   = 1'b0;
    Cs          = 1'b0;
    Wena        = 1'b0;
    Bus_req     = 1'b0;
    if (active) begin
      unique case (state_q)
        StIdle: begin
          if (!RX_Empty) begin
            Bus_req = 1'b1;
            state_d = StBusReq;
          end
        end
        StBusReq: begin
          Bus_req = 1'b1;
          if (Bus_grant) state_d = StRead;
        end
        StRead: begin
          Bus_req   = 1'b1;
          Data_Read = 1'b1;
          state_d   = StWrite;
        end
        StWrite: begin
          Bus_req = 1'b1;
          Cs      = 1'b1;
          Wena    = 1'b1;
          Address = BaseAddr + ADDR_W'(idx_q);
          Databus = RX_Data;
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else if (!RX_Empty) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StRead;
          end else begin
`ifdef DMA_RX_TIMEOUT_EN
            state_d = StWait;
`else
            state_d = StDone;
`endif
          end
        end
        StWait: begin
`ifdef DMA_RX_TIMEOUT_EN
          Bus_req = 1'b1;
          if (!RX_Empty) begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StRead;
          end else if (wait_expired) begin
            tmo_d   = 1'b1;
            state_d = StDone;
          end
`else
          state_d = StIdle;
`endif
        end
        StDone: begin
          Bus_req    = 1'b1;
          Dma_End    = 1'b1;
          Byte_Count = CntW'(idx_q) + CntW'(1);
          idx_d      = '0;
          state_d    = StIdle;
`ifdef DMA_RX_TIMEOUT_EN
          Dma_Timeout = tmo_q;
          tmo_d       = 1'b0;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else if (Ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule
